// File: rtl/dekatron_step_sequencer.sv
// Dekatron step sequencer: walks the glow to a requested BCD digit by the shortest
// direction around the ring, issuing guide-1/guide-2 pulse pairs for each step.

module BcdToBin (
   input  logic [3:0] Bcd,
   output logic [9:0] OneHot
);
   always_comb begin
      OneHot = '0;
      for (int i = 0; i < 10; i++) begin
         if (Bcd == 4'(i)) OneHot[i] = 1'b1;
      end
   end
endmodule

module dekatron_step_sequencer #(
   parameter int PULSE_CYCLES = 2,
   parameter int GAP_CYCLES   = 1
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       Request,
   input  logic [3:0] Target,
   output logic       Busy,
   output logic       Done,
   output logic       Err,
   output logic       Guide1,
   output logic       Guide2,
   output logic       Dir,
   output logic [3:0] Position,
   output logic [9:0] PositionOneHot
);

   localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FIRST  = 3'd1,
      S_SECOND = 3'd2,
      S_GAP    = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      steps_q, steps_d;
   logic            dir_q, dir_d;
   logic [3:0]      pos_q, pos_d;
   logic            err_q, err_d;

   logic [4:0]      diff;
   logic [3:0]      fwd;

   // State register
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         steps_q <= '0;
         dir_q   <= 1'b0;
         pos_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         steps_q <= steps_d;
         dir_q   <= dir_d;
         pos_q   <= pos_d;
         err_q   <= err_d;
      end
   end

   // Forward distance around the ring, (Target - Position) mod 10
   always_comb begin
      diff = 5'd10 + {1'b0, Target} - {1'b0, pos_q};
      fwd  = (diff >= 5'd10) ? 4'(diff - 5'd10) : diff[3:0];
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      steps_d = steps_q;
      dir_d   = dir_q;
      pos_d   = pos_q;
      err_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (Request) begin
               cnt_d = '0;
               if (Target > 4'd9) begin
                  err_d = 1'b1;
               end else if (fwd == 4'd0) begin
                  dir_d   = 1'b0;
                  state_d = S_DONE;
               end else if (fwd <= 4'd5) begin
                  dir_d   = 1'b0;
                  steps_d = fwd[2:0];
                  state_d = S_FIRST;
               end else begin
                  dir_d   = 1'b1;
                  steps_d = 3'(4'd10 - fwd);
                  state_d = S_FIRST;
               end
            end
         end
         S_FIRST: begin
            if (cnt_q == PULSE_LAST) begin
               cnt_d   = '0;
               state_d = S_SECOND;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SECOND: begin
            if (cnt_q == PULSE_LAST) begin
               cnt_d   = '0;
               steps_d = steps_q - 3'd1;
               if (!dir_q) pos_d = (pos_q == 4'd9) ? 4'd0 : pos_q + 4'd1;
               else        pos_d = (pos_q == 4'd0) ? 4'd9 : pos_q - 4'd1;
               state_d = (steps_q == 3'd1) ? S_DONE : S_GAP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = S_FIRST;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs; the leading guide of each pair follows the move direction
   always_comb begin
      Busy   = 1'b0;
      Done   = 1'b0;
      Guide1 = 1'b0;
      Guide2 = 1'b0;
      unique case (state_q)
         S_FIRST: begin
            Busy   = 1'b1;
            Guide1 = ~dir_q;
            Guide2 = dir_q;
         end
         S_SECOND: begin
            Busy   = 1'b1;
            Guide1 = dir_q;
            Guide2 = ~dir_q;
         end
         S_GAP:   Busy = 1'b1;
         S_DONE:  Done = 1'b1;
         default: ;
      endcase
   end

   assign Err      = err_q;
   assign Dir      = dir_q;
   assign Position = pos_q;

   BcdToBin u_decode (
      .Bcd    (pos_q),
      .OneHot (PositionOneHot)
   );

endmodule

// File: tb/tb_dekatron_step_sequencer.sv
// Bench for dekatron_step_sequencer: directed scenarios plus random moves, checked
// cycle by cycle against a ring-arithmetic model of the expected pulse train.

module tb_dekatron_step_sequencer;

  localparam int P = 2;
  localparam int G = 1;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       Request;
  logic [3:0] Target;
  logic       Busy, Done, Err, Guide1, Guide2, Dir;
  logic [3:0] Position;
  logic [9:0] PositionOneHot;

  int checks = 0;
  int errors = 0;
  int model_pos = 0;
  logic [3:0] exp_q[$];

  dekatron_step_sequencer #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .Clk            (Clk),
    .Rst_n          (Rst_n),
    .Request        (Request),
    .Target         (Target),
    .Busy           (Busy),
    .Done           (Done),
    .Err            (Err),
    .Guide1         (Guide1),
    .Guide2         (Guide2),
    .Dir            (Dir),
    .Position       (Position),
    .PositionOneHot (PositionOneHot)
  );

  // clock
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_pos(input string tag, input int p);
    check({tag, "_pos"}, 32'(Position), 32'(p));
    check({tag, "_onehot"}, 32'(PositionOneHot), 32'd1 << p);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(Busy), 0);
    check({tag, "_done"}, 32'(Done), 0);
    check({tag, "_g1"}, 32'(Guide1), 0);
    check({tag, "_g2"}, 32'(Guide2), 0);
  endtask

  function automatic int ring(input int v);
    return ((v % 10) + 10) % 10;
  endfunction

  // driver: reset pulse, checked immediately while Rst_n is low
  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check_idle_outputs("reset");
    check("reset_err", 32'(Err), 0);
    check("reset_dir", 32'(Dir), 0);
    check_pos("reset", 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    model_pos = 0;
    exp_q.delete();
  endtask

  // driver + model: one request, then every cycle up to completion is checked
  task automatic do_move(input logic [3:0] tgt, input bit noisy);
    int fwd, n, d, total, per, s, ph, stepped, e_pos;
    bit lead, trail;
    @(negedge Clk);
    Request = 1'b1;
    Target  = tgt;
    @(posedge Clk);
    #1;
    Request = 1'b0;
    @(negedge Clk);
    if (tgt > 4'd9) begin
      check("err_pulse", 32'(Err), 1);
      check_idle_outputs("err");
      check_pos("err", model_pos);
      @(negedge Clk);
      check("err_clear", 32'(Err), 0);
      check("err_nobusy", 32'(Busy), 0);
      return;
    end
    fwd   = ring(int'(tgt) - model_pos);
    d     = (fwd > 5) ? 1 : 0;
    n     = d ? 10 - fwd : fwd;
    total = (n == 0) ? 0 : n * 2 * P + (n - 1) * G;
    per   = 2 * P + G;
    exp_q.push_back(tgt);
    for (int t = 1; t <= total; t++) begin
      s       = (t - 1) / per;
      ph      = (t - 1) % per;
      lead    = (ph < P);
      trail   = (ph >= P) && (ph < 2 * P);
      stepped = s + ((ph >= 2 * P) ? 1 : 0);
      e_pos   = d ? ring(model_pos - stepped) : ring(model_pos + stepped);
      check("mv_busy", 32'(Busy), 1);
      check("mv_done", 32'(Done), 0);
      check("mv_dir", 32'(Dir), 32'(d));
      check("mv_g1", 32'(Guide1), d ? 32'(trail) : 32'(lead));
      check("mv_g2", 32'(Guide2), d ? 32'(lead) : 32'(trail));
      check_pos("mv", e_pos);
      if (noisy) begin
        Request = 1'($urandom_range(0, 1));
        Target  = 4'($urandom_range(0, 15));
      end
      @(negedge Clk);
    end
    Request = 1'b0;
    check("fin_done", 32'(Done), 1);
    check("fin_busy", 32'(Busy), 0);
    check("fin_g1", 32'(Guide1), 0);
    check("fin_g2", 32'(Guide2), 0);
    check("fin_err", 32'(Err), 0);
    check_pos("fin", int'(exp_q.pop_front()));
    model_pos = int'(tgt);
    @(negedge Clk);
    check("post_done", 32'(Done), 0);
  endtask

  initial begin
    Rst_n   = 1'b0;
    Request = 1'b0;
    Target  = 4'd0;
    #2;
    check_idle_outputs("por");
    check_pos("por", 0);
    do_reset();

    do_move(4'd3, 1'b0);          // forward, 3 steps
    do_reset();
    do_move(4'd7, 1'b0);          // backward through 9, 8, 7
    do_move(4'd0, 1'b0);          // forward wrap 8, 9, 0
    do_move(4'd5, 1'b0);          // tie at 5 goes forward
    do_move(4'd5, 1'b0);          // zero-step move
    do_move(4'hC, 1'b0);          // rejected target
    do_move(4'd1, 1'b0);
    do_move(4'd8, 1'b1);          // request/target noise during the move

    // reset during the second guide pulse of a forward move
    do_reset();
    @(negedge Clk);
    Request = 1'b1;
    Target  = 4'd3;
    @(posedge Clk);
    #1;
    Request = 1'b0;
    repeat (P + 1) @(negedge Clk);
    check("pre_rst_g2", 32'(Guide2), 1);
    #2;
    Rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    check("midrst_dir", 32'(Dir), 0);
    check_pos("midrst", 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    model_pos = 0;
    exp_q.delete();
    do_move(4'd2, 1'b0);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 4) == 0) do_move(4'($urandom_range(10, 15)), 1'b0);
      else do_move(4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
